// File: rtl/el2_pkg.sv
`default_nettype none
// ============================================================================
// el2_pkg : shared types for the decode trigger controller.
// Revision: 1.0
// ============================================================================
package el2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    BLOCK = 2'd2
  } el2_trig_ctl_state_e;

endpackage
`default_nettype wire

// File: rtl/el2_trig_chain_qual.sv
`default_nettype none
// ============================================================================
// el2_trig_chain_qual : qualifies raw trigger matches and applies pair chaining.
// Revision: 1.0
// ============================================================================
module el2_trig_chain_qual #(
  parameter int NUM_TRIG = 4
) (
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [NUM_TRIG-1:0]   match_i,
  input  logic [NUM_TRIG/2-1:0] chain_i,
  output logic [NUM_TRIG-1:0]   fired_o
);

  logic [NUM_TRIG-1:0] qual;

  assign qual = match_i & {NUM_TRIG{valid_i & ~flush_i}};

  for (genvar k = 0; k < NUM_TRIG/2; k++) begin : g_pair
    logic both;
    // A chained pair is all-or-nothing: one half alone never fires.
    assign both             = qual[2*k] & qual[2*k+1];
    assign fired_o[2*k]     = chain_i[k] ? both : qual[2*k];
    assign fired_o[2*k+1]   = chain_i[k] ? both : qual[2*k+1];
  end

endmodule
`default_nettype wire

// File: rtl/el2_dec_trigger_ctl.sv
`default_nettype none
// ============================================================================
// el2_dec_trigger_ctl : turns decode trigger hits into a registered TLU request.
// Revision: 1.0
// ============================================================================
module el2_dec_trigger_ctl
  import el2_pkg::*;
#(
  parameter int NUM_TRIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_i0_valid_d,
  input  logic [NUM_TRIG-1:0]   dec_i0_trigger_match_d,
  input  logic [NUM_TRIG/2-1:0] trig_chain,
  input  logic [NUM_TRIG-1:0]   trig_action,
  input  logic                  dec_flush,
  input  logic                  tlu_trig_ack,
  input  logic [NUM_TRIG-1:0]   trig_hit_clr,
  output logic                  trig_req,
  output logic                  trig_req_dbg,
  output logic [NUM_TRIG-1:0]   trig_req_hit,
  output logic [NUM_TRIG-1:0]   trig_hit_sticky,
  output logic                  trig_busy
);

  el2_trig_ctl_state_e state_q;
  logic                req_q;
  logic                dbg_q;
  logic [NUM_TRIG-1:0] hit_q;
  logic [NUM_TRIG-1:0] sticky_q;
  logic [NUM_TRIG-1:0] sticky_d;
  logic [NUM_TRIG-1:0] fired;
  logic [NUM_TRIG-1:0] fired_idle;

  el2_trig_chain_qual #(
    .NUM_TRIG (NUM_TRIG)
  ) u_chain_qual (
    .valid_i  (dec_i0_valid_d),
    .flush_i  (dec_flush),
    .match_i  (dec_i0_trigger_match_d),
    .chain_i  (trig_chain),
    .fired_o  (fired)
  );

  // Hits only count while idle; PEND and BLOCK ignore the comparator.
  always_comb begin
    fired_idle = (state_q == IDLE) ? fired : '0;
    sticky_d   = (sticky_q & ~trig_hit_clr) | fired_idle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      dbg_q    <= 1'b0;
      hit_q    <= '0;
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
      case (state_q)
        IDLE: begin
          if (|fired) begin
            state_q <= PEND;
            req_q   <= 1'b1;
            hit_q   <= fired;
            dbg_q   <= |(fired & trig_action);
          end
        end
        PEND: begin
          // Ack takes priority over a same-cycle flush.
          if (tlu_trig_ack) begin
            state_q <= BLOCK;
            req_q   <= 1'b0;
            hit_q   <= '0;
            dbg_q   <= 1'b0;
          end else if (dec_flush) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            hit_q   <= '0;
            dbg_q   <= 1'b0;
          end
        end
        BLOCK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          hit_q   <= '0;
          dbg_q   <= 1'b0;
        end
      endcase
    end
  end

  assign trig_req        = req_q;
  assign trig_req_dbg    = dbg_q;
  assign trig_req_hit    = hit_q;
  assign trig_hit_sticky = sticky_q;
  assign trig_busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_el2_dec_trigger_ctl.sv
`default_nettype none
// ============================================================================
// tb_el2_dec_trigger_ctl : directed and random checks against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_el2_dec_trigger_ctl;

  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [NT-1:0] match = '0;
  logic [NT/2-1:0] chain = '0;
  logic [NT-1:0] action = '0;
  logic          flush = 1'b0;
  logic          ack = 1'b0;
  logic [NT-1:0] clr = '0;
  logic          req, dbg, busy;
  logic [NT-1:0] hit, sticky;

  int nvec = 0;
  int nerr = 0;

  el2_dec_trigger_ctl #(.NUM_TRIG(NT)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .dec_i0_valid_d         (valid),
    .dec_i0_trigger_match_d (match),
    .trig_chain             (chain),
    .trig_action            (action),
    .dec_flush              (flush),
    .tlu_trig_ack           (ack),
    .trig_hit_clr           (clr),
    .trig_req               (req),
    .trig_req_dbg           (dbg),
    .trig_req_hit           (hit),
    .trig_hit_sticky        (sticky),
    .trig_busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = request pending, 2 = blocked.
  int            m_mode;
  logic [NT-1:0] m_hit, m_sticky;
  logic          m_dbg, m_zero_hit, m_zero_dbg;

  function automatic logic [NT-1:0] fire_of(logic [NT-1:0] m, logic [NT/2-1:0] ch,
                                            logic v, logic fl);
    logic [NT-1:0] r;
    r = (v && !fl) ? m : '0;
    for (int k = 0; k < NT/2; k++)
      if (ch[k] && !(r[2*k] && r[2*k+1])) begin
        r[2*k]   = 1'b0;
        r[2*k+1] = 1'b0;
      end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_hit <= '0; m_dbg <= 1'b0; m_sticky <= '0;
      m_zero_hit <= 1'b1; m_zero_dbg <= 1'b1;
    end else if (m_mode == 0) begin
      m_sticky <= (m_sticky & ~clr) | fire_of(match, chain, valid, flush);
      if (fire_of(match, chain, valid, flush) != '0) begin
        m_mode <= 1;
        m_hit  <= fire_of(match, chain, valid, flush);
        m_dbg  <= |(fire_of(match, chain, valid, flush) & action);
        m_zero_hit <= 1'b0; m_zero_dbg <= 1'b0;
      end
    end else begin
      m_sticky <= m_sticky & ~clr;
      if (m_mode == 2) m_mode <= 0;
      else if (ack) m_mode <= 2;
      else if (flush) begin
        m_mode <= 0;
        m_zero_hit <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("req",    {31'd0, req},    {31'd0, m_mode == 1});
    chk("busy",   {31'd0, busy},   {31'd0, m_mode != 0});
    chk("sticky", {28'd0, sticky}, {28'd0, m_sticky});
    if (m_mode == 1) begin
      chk("hit", {28'd0, hit}, {28'd0, m_hit});
      chk("dbg", {31'd0, dbg}, {31'd0, m_dbg});
    end else begin
      if (m_zero_hit) chk("hit_zero", {28'd0, hit}, 32'd0);
      if (m_zero_dbg) chk("dbg_zero", {31'd0, dbg}, 32'd0);
    end
  end

  task automatic quiet();
    valid = 0; match = '0; chain = '0; action = '0; flush = 0; ack = 0; clr = '0;
  endtask

  task automatic hitv(input logic [NT-1:0] m, input logic [NT/2-1:0] ch, input logic [NT-1:0] a);
    quiet(); valid = 1; match = m; chain = ch; action = a;
  endtask

  initial begin
    quiet();
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hit", {28'd0, hit}, 32'd0);
    chk("rst_sticky", {28'd0, sticky}, 32'd0);
    rst = 0;

    // Single unchained hit, one-cycle latency.
    hitv(4'b0001, 2'b00, 4'b0000);
    @(negedge clk); quiet();
    chk("d1_req", {31'd0, req}, 32'd1);
    chk("d1_hit", {28'd0, hit}, 32'h1);
    chk("d1_dbg", {31'd0, dbg}, 32'd0);
    chk("d1_sticky", {28'd0, sticky}, 32'h1);
    ack = 1; @(negedge clk); quiet();
    chk("d1_ack_req", {31'd0, req}, 32'd0);
    chk("d1_block", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("d1_idle", {31'd0, busy}, 32'd0);

    // Chained pair needs both halves.
    hitv(4'b0001, 2'b01, 4'b0000);
    @(negedge clk);
    chk("d2_half", {31'd0, req}, 32'd0);
    hitv(4'b0011, 2'b01, 4'b0000);
    @(negedge clk); quiet();
    chk("d2_hit", {28'd0, hit}, 32'h3);
    ack = 1; @(negedge clk); quiet(); @(negedge clk);

    // New match while pending is ignored; blocked cycle ignores matches too.
    hitv(4'b0100, 2'b00, 4'b0000);
    @(negedge clk); hitv(4'b1000, 2'b00, 4'b0000);
    @(negedge clk);
    chk("d3_hold", {28'd0, hit}, 32'h4);
    ack = 1; @(negedge clk); ack = 0;
    chk("d3_req_low", {31'd0, req}, 32'd0);
    @(negedge clk); quiet();
    chk("d3_no_second", {31'd0, req}, 32'd0);
    chk("d3_sticky", {28'd0, sticky}, 32'h7);

    // Flush kills a same-cycle hit, and a pending request.
    hitv(4'b0010, 2'b00, 4'b0000); flush = 1;
    @(negedge clk); quiet();
    chk("d4_flush_hit", {31'd0, req}, 32'd0);
    chk("d4_sticky", {28'd0, sticky}, 32'h7);
    hitv(4'b0001, 2'b00, 4'b0000);
    @(negedge clk); quiet(); flush = 1;
    @(negedge clk); quiet();
    chk("d4_drop_req", {31'd0, req}, 32'd0);
    chk("d4_drop_busy", {31'd0, busy}, 32'd0);
    chk("d4_drop_hit", {28'd0, hit}, 32'd0);

    // Debug action, and set beating clear on the sticky bit.
    hitv(4'b1100, 2'b00, 4'b0100);
    @(negedge clk); quiet();
    chk("d5_dbg", {31'd0, dbg}, 32'd1);
    chk("d5_hit", {28'd0, hit}, 32'hC);
    ack = 1; @(negedge clk); quiet(); @(negedge clk);
    hitv(4'b0100, 2'b00, 4'b0000); clr = 4'b0100;
    @(negedge clk); quiet();
    chk("d5_sticky_set_wins", {28'd0, sticky}, 32'hF);
    clr = 4'b1111; flush = 1;
    @(negedge clk); quiet();
    chk("d5_sticky_clr", {28'd0, sticky}, 32'h0);

    // Asynchronous reset in the middle of a pending request.
    hitv(4'b0001, 2'b00, 4'b0001);
    @(negedge clk); quiet();
    chk("d6_pend", {31'd0, req}, 32'd1);
    #2 rst = 1;
    #1;
    chk("d6_async_req", {31'd0, req}, 32'd0);
    chk("d6_async_dbg", {31'd0, dbg}, 32'd0);
    chk("d6_async_busy", {31'd0, busy}, 32'd0);
    chk("d6_async_hit", {28'd0, hit}, 32'd0);
    @(negedge clk); rst = 0;
    hitv(4'b0010, 2'b00, 4'b0000);
    @(negedge clk); quiet();
    chk("d6_after_req", {31'd0, req}, 32'd1);
    chk("d6_after_hit", {28'd0, hit}, 32'h2);

    // Random traffic checked each cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      valid  = ($urandom_range(3) != 0);
      match  = NT'($urandom);
      chain  = (NT/2)'($urandom);
      action = NT'($urandom);
      flush  = ($urandom_range(9) == 0);
      ack    = ($urandom_range(2) == 0);
      clr    = ($urandom_range(7) == 0) ? NT'($urandom) : '0;
      if (n == 1500) begin
        #3 rst = 1; #1 rst = 0;
      end
      @(negedge clk);
    end
    quiet();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
